// File: rtl/riscv_victim_ctrl_if.sv
// Bundle of the L1-miss, victim-cache and memory-port signals seen by riscv_victim_ctrl.
// master = controller side, slave = environment (L1 FSM, VC array, memory).
`ifndef TAG_BITS
`define TAG_BITS 8
`endif
`ifndef IDX_BITS
`define IDX_BITS 4
`endif
`ifndef BLK_SIZE
`define BLK_SIZE 32
`endif

interface riscv_victim_ctrl_if #(
  parameter int TAG_W = `TAG_BITS,
  parameter int IDX_W = `IDX_BITS,
  parameter int BLK_W = `BLK_SIZE
);
  logic                   miss_val, miss_rdy;
  logic [TAG_W-1:0]       miss_tag;
  logic [IDX_W-1:0]       miss_idx;
  logic                   evict_val, evict_dirty;
  logic [TAG_W-1:0]       evict_tag;
  logic [BLK_W-1:0]       evict_data;
  logic                   fill_val, fill_dirty, fill_from_vc;
  logic [BLK_W-1:0]       fill_data;
  logic                   vc_lookup_en;
  logic [TAG_W-1:0]       vc_lookup_tag;
  logic [IDX_W-1:0]       vc_lookup_idx;
  logic                   vc_lookup_hit, vc_lookup_way, vc_repl_way;
  logic [BLK_W-1:0]       vc_lookup_data;
  logic [1:0]             vc_valid_bits;
  logic                   vc_write_en, vc_write_way, vc_write_valid;
  logic [TAG_W-1:0]       vc_write_tag;
  logic [IDX_W-1:0]       vc_write_idx;
  logic [BLK_W-1:0]       vc_write_data;
  logic                   memreq_val, memreq_rdy, memreq_type;
  logic [TAG_W+IDX_W-1:0] memreq_addr;
  logic [BLK_W-1:0]       memreq_data;
  logic                   memresp_val;
  logic [BLK_W-1:0]       memresp_data;

  modport master (
    input  miss_val, miss_tag, miss_idx, evict_val, evict_dirty, evict_tag, evict_data,
           vc_lookup_hit, vc_lookup_way, vc_lookup_data, vc_valid_bits, vc_repl_way,
           memreq_rdy, memresp_val, memresp_data,
    output miss_rdy, fill_val, fill_data, fill_dirty, fill_from_vc,
           vc_lookup_en, vc_lookup_tag, vc_lookup_idx,
           vc_write_en, vc_write_way, vc_write_tag, vc_write_idx, vc_write_data, vc_write_valid,
           memreq_val, memreq_type, memreq_addr, memreq_data
  );

  modport slave (
    output miss_val, miss_tag, miss_idx, evict_val, evict_dirty, evict_tag, evict_data,
           vc_lookup_hit, vc_lookup_way, vc_lookup_data, vc_valid_bits, vc_repl_way,
           memreq_rdy, memresp_val, memresp_data,
    input  miss_rdy, fill_val, fill_data, fill_dirty, fill_from_vc,
           vc_lookup_en, vc_lookup_tag, vc_lookup_idx,
           vc_write_en, vc_write_way, vc_write_tag, vc_write_idx, vc_write_data, vc_write_valid,
           memreq_val, memreq_type, memreq_addr, memreq_data
  );
endinterface

// File: rtl/riscv_victim_ctrl.sv
// L1-miss controller for a 2-way victim cache: swap on VC hit, else memory fill plus victim insert/writeback.
// Hit fills 2 cycles after accept; one miss in flight; memreq fields held while memreq_rdy=0. Counters: RISCV_VICTIM_CTRL_PERF_EN.
`ifndef TAG_BITS
`define TAG_BITS 8
`endif
`ifndef IDX_BITS
`define IDX_BITS 4
`endif
`ifndef BLK_SIZE
`define BLK_SIZE 32
`endif

module riscv_victim_ctrl #(
  parameter int TAG_W = `TAG_BITS,
  parameter int IDX_W = `IDX_BITS,
  parameter int BLK_W = `BLK_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  riscv_victim_ctrl_if.master bus,
  output logic [31:0]         perf_hit,
  output logic [31:0]         perf_miss,
  output logic [31:0]         perf_wb
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_SWAP, S_RD_REQ, S_RD_WAIT, S_VC_RD, S_WB_REQ, S_INSERT
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             ev_val;
    logic             ev_dirty;
    logic [TAG_W-1:0] ev_tag;
    logic [BLK_W-1:0] ev_data;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic             way_q, way_d, repl_q, repl_d;
  logic [BLK_W-1:0] data_q, data_d;
  // The VC array keeps no dirty bit, so the controller tracks what it wrote per way.
  logic [TAG_W-1:0] sh_tag_q [2];
  logic [TAG_W-1:0] sh_tag_d [2];
  logic [IDX_W-1:0] sh_idx_q [2];
  logic [IDX_W-1:0] sh_idx_d [2];
  logic [1:0]       sh_dirty_q, sh_dirty_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      way_q      <= 1'b0;
      repl_q     <= 1'b0;
      data_q     <= '0;
      sh_tag_q   <= '{default: '0};
      sh_idx_q   <= '{default: '0};
      sh_dirty_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      way_q      <= way_d;
      repl_q     <= repl_d;
      data_q     <= data_d;
      sh_tag_q   <= sh_tag_d;
      sh_idx_q   <= sh_idx_d;
      sh_dirty_q <= sh_dirty_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    way_d      = way_q;
    repl_d     = repl_q;
    data_d     = data_q;
    sh_tag_d   = sh_tag_q;
    sh_idx_d   = sh_idx_q;
    sh_dirty_d = sh_dirty_q;
    case (state_q)
      S_IDLE: if (bus.miss_val) begin
        req_d.tag      = bus.miss_tag;
        req_d.idx      = bus.miss_idx;
        req_d.ev_val   = bus.evict_val;
        req_d.ev_dirty = bus.evict_dirty;
        req_d.ev_tag   = bus.evict_tag;
        req_d.ev_data  = bus.evict_data;
        state_d        = S_LOOKUP;
      end
      S_LOOKUP: begin
        way_d   = bus.vc_lookup_way;
        repl_d  = bus.vc_repl_way;
        data_d  = bus.vc_lookup_data;
        state_d = bus.vc_lookup_hit ? S_SWAP : S_RD_REQ;
      end
      S_SWAP: begin
        sh_dirty_d[way_q] = req_q.ev_val & req_q.ev_dirty;
        if (req_q.ev_val) begin
          sh_tag_d[way_q] = req_q.ev_tag;
          sh_idx_d[way_q] = req_q.idx;
        end
        state_d = S_IDLE;
      end
      S_RD_REQ: if (bus.memreq_rdy) state_d = S_RD_WAIT;
      S_RD_WAIT: if (bus.memresp_val) begin
        if (!req_q.ev_val)
          state_d = S_IDLE;
        else if (bus.vc_valid_bits[repl_q] && sh_dirty_q[repl_q])
          state_d = S_VC_RD;
        else
          state_d = S_INSERT;
      end
      S_VC_RD: begin
        data_d  = bus.vc_lookup_data;
        state_d = S_WB_REQ;
      end
      S_WB_REQ: if (bus.memreq_rdy) state_d = S_INSERT;
      S_INSERT: begin
        sh_dirty_d[repl_q] = req_q.ev_dirty;
        sh_tag_d[repl_q]   = req_q.ev_tag;
        sh_idx_d[repl_q]   = req_q.idx;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.miss_rdy       = (state_q == S_IDLE) && !reset;
    bus.fill_val       = 1'b0;
    bus.fill_data      = '0;
    bus.fill_dirty     = 1'b0;
    bus.fill_from_vc   = 1'b0;
    bus.vc_lookup_en   = 1'b0;
    bus.vc_lookup_tag  = '0;
    bus.vc_lookup_idx  = '0;
    bus.vc_write_en    = 1'b0;
    bus.vc_write_way   = 1'b0;
    bus.vc_write_tag   = '0;
    bus.vc_write_idx   = '0;
    bus.vc_write_data  = '0;
    bus.vc_write_valid = 1'b0;
    bus.memreq_val     = 1'b0;
    bus.memreq_type    = 1'b0;
    bus.memreq_addr    = '0;
    bus.memreq_data    = '0;
    case (state_q)
      S_LOOKUP: begin
        bus.vc_lookup_en  = 1'b1;
        bus.vc_lookup_tag = req_q.tag;
        bus.vc_lookup_idx = req_q.idx;
      end
      S_SWAP: begin
        bus.fill_val     = 1'b1;
        bus.fill_data    = data_q;
        bus.fill_dirty   = sh_dirty_q[way_q];
        bus.fill_from_vc = 1'b1;
        bus.vc_write_en  = 1'b1;
        bus.vc_write_way = way_q;
        bus.vc_write_idx = req_q.idx;
        if (req_q.ev_val) begin
          bus.vc_write_tag   = req_q.ev_tag;
          bus.vc_write_data  = req_q.ev_data;
          bus.vc_write_valid = 1'b1;
        end
      end
      S_RD_REQ: begin
        bus.memreq_val  = 1'b1;
        bus.memreq_addr = {req_q.tag, req_q.idx};
      end
      S_RD_WAIT: begin
        bus.fill_val  = bus.memresp_val;
        bus.fill_data = bus.memresp_data;
      end
      S_VC_RD: begin
        bus.vc_lookup_en  = 1'b1;
        bus.vc_lookup_tag = sh_tag_q[repl_q];
        bus.vc_lookup_idx = sh_idx_q[repl_q];
      end
      S_WB_REQ: begin
        bus.memreq_val  = 1'b1;
        bus.memreq_type = 1'b1;
        bus.memreq_addr = {sh_tag_q[repl_q], sh_idx_q[repl_q]};
        bus.memreq_data = data_q;
      end
      S_INSERT: begin
        bus.vc_write_en    = 1'b1;
        bus.vc_write_way   = repl_q;
        bus.vc_write_tag   = req_q.ev_tag;
        bus.vc_write_idx   = req_q.idx;
        bus.vc_write_data  = req_q.ev_data;
        bus.vc_write_valid = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef RISCV_VICTIM_CTRL_PERF_EN
  logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d, perf_wb_q, perf_wb_d;

  always_comb begin
    perf_hit_d  = perf_hit_q;
    perf_miss_d = perf_miss_q;
    perf_wb_d   = perf_wb_q;
    if (state_q == S_LOOKUP && state_d == S_SWAP)   perf_hit_d  = perf_hit_q + 32'd1;
    if (state_q == S_LOOKUP && state_d == S_RD_REQ) perf_miss_d = perf_miss_q + 32'd1;
    if (state_q == S_WB_REQ && bus.memreq_rdy)      perf_wb_d   = perf_wb_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
      perf_wb_q   <= '0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
      perf_wb_q   <= perf_wb_d;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
  assign perf_wb   = perf_wb_q;
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
  assign perf_wb   = '0;
`endif

endmodule

// File: tb/tb_riscv_victim_ctrl.sv
// Directed bench for riscv_victim_ctrl: reset abort, VC miss fill/insert, VC hit swap, stalls, dirty writeback.
`ifndef TAG_BITS
`define TAG_BITS 8
`endif
`ifndef IDX_BITS
`define IDX_BITS 4
`endif
`ifndef BLK_SIZE
`define BLK_SIZE 32
`endif

module tb_riscv_victim_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] perf_hit, perf_miss, perf_wb;
  int          checks = 0;
  int          errors = 0;

  riscv_victim_ctrl_if bus ();

  riscv_victim_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .perf_hit  (perf_hit),
    .perf_miss (perf_miss),
    .perf_wb   (perf_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic miss(input logic [7:0] tag, input logic [3:0] idx, input logic ev,
                      input logic dirty, input logic [7:0] etag, input logic [31:0] edata);
    bus.miss_val    = 1'b1;
    bus.miss_tag    = tag;
    bus.miss_idx    = idx;
    bus.evict_val   = ev;
    bus.evict_dirty = dirty;
    bus.evict_tag   = etag;
    bus.evict_data  = edata;
  endtask

  task automatic strobes_idle(input string tag);
    chk({tag, "_fill_val"}, bus.fill_val, 1'b0);
    chk({tag, "_lookup_en"}, bus.vc_lookup_en, 1'b0);
    chk({tag, "_write_en"}, bus.vc_write_en, 1'b0);
    chk({tag, "_memreq_val"}, bus.memreq_val, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.miss_val = 0; bus.miss_tag = 0; bus.miss_idx = 0;
    bus.evict_val = 0; bus.evict_dirty = 0; bus.evict_tag = 0; bus.evict_data = 0;
    bus.vc_lookup_hit = 0; bus.vc_lookup_way = 0; bus.vc_lookup_data = 0;
    bus.vc_valid_bits = 2'b00; bus.vc_repl_way = 0;
    bus.memreq_rdy = 0; bus.memresp_val = 0; bus.memresp_data = 0;

    // Reset state
    #3;
    chk("rst_miss_rdy", bus.miss_rdy, 1'b0);
    strobes_idle("rst");
    chk("rst_fill_data", bus.fill_data, 32'h0);
    chk("rst_memreq_addr", bus.memreq_addr, 12'h0);
    chk("rst_perf_hit", perf_hit, 32'd0);
    step(); reset = 1'b0; #1;
    chk("rel_miss_rdy", bus.miss_rdy, 1'b1);

    // Reset pulse in RD_WAIT abandons the read; late response is ignored
    step(); miss(8'h01, 4'h1, 1'b0, 1'b0, 8'h00, 32'h0); #1;
    chk("r_accept_rdy", bus.miss_rdy, 1'b1);
    step(); bus.miss_val = 0; #1;
    chk("r_lookup_en", bus.vc_lookup_en, 1'b1);
    step(); bus.memreq_rdy = 1; #1;
    chk("r_rdreq_val", bus.memreq_val, 1'b1);
    chk("r_rdreq_addr", bus.memreq_addr, 12'h011);
    step(); bus.memreq_rdy = 0; reset = 1'b1; #1;
    chk("r_mid_miss_rdy", bus.miss_rdy, 1'b0);
    strobes_idle("r_mid");
    bus.memresp_val = 1; bus.memresp_data = 32'hDEADBEEF;
    step(); reset = 1'b0; #1;
    chk("r_after_miss_rdy", bus.miss_rdy, 1'b1);
    strobes_idle("r_after");
    step(); bus.memresp_val = 0; #1;
    chk("r_idle_fill", bus.fill_val, 1'b0);

    // VC empty: miss {05,2}, clean evict {12,2}
    miss(8'h05, 4'h2, 1'b1, 1'b0, 8'h12, 32'hEEEE0012); #1;
    chk("a_accept_rdy", bus.miss_rdy, 1'b1);
    step(); bus.miss_val = 0; #1;
    chk("a_lookup_en", bus.vc_lookup_en, 1'b1);
    chk("a_lookup_tag", bus.vc_lookup_tag, 8'h05);
    chk("a_lookup_idx", bus.vc_lookup_idx, 4'h2);
    chk("a_lookup_rdy", bus.miss_rdy, 1'b0);
    step(); bus.memreq_rdy = 1; #1;
    chk("a_rdreq_val", bus.memreq_val, 1'b1);
    chk("a_rdreq_type", bus.memreq_type, 1'b0);
    chk("a_rdreq_addr", bus.memreq_addr, 12'h052);
    step(); bus.memreq_rdy = 0; #1;
    chk("a_wait_fill", bus.fill_val, 1'b0);
    chk("a_wait_memreq", bus.memreq_val, 1'b0);
    step(); bus.memresp_val = 1; bus.memresp_data = 32'hABABABAB; #1;
    chk("a_fill_val", bus.fill_val, 1'b1);
    chk("a_fill_data", bus.fill_data, 32'hABABABAB);
    chk("a_fill_from_vc", bus.fill_from_vc, 1'b0);
    chk("a_fill_dirty", bus.fill_dirty, 1'b0);
    chk("a_fill_nowrite", bus.vc_write_en, 1'b0);
    step(); bus.memresp_val = 0; #1;
    chk("a_ins_wen", bus.vc_write_en, 1'b1);
    chk("a_ins_way", bus.vc_write_way, 1'b0);
    chk("a_ins_tag", bus.vc_write_tag, 8'h12);
    chk("a_ins_idx", bus.vc_write_idx, 4'h2);
    chk("a_ins_valid", bus.vc_write_valid, 1'b1);
    chk("a_ins_data", bus.vc_write_data, 32'hEEEE0012);
    chk("a_ins_nomem", bus.memreq_val, 1'b0);
    chk("a_ins_rdy", bus.miss_rdy, 1'b0);
    step(); #1;
    chk("a_done_rdy", bus.miss_rdy, 1'b1);

    // VC hit: miss {12,2}, dirty evict {34,2}
    bus.vc_valid_bits = 2'b01;
    miss(8'h12, 4'h2, 1'b1, 1'b1, 8'h34, 32'h34343434); #1;
    step(); bus.miss_val = 0;
    bus.vc_lookup_hit = 1; bus.vc_lookup_way = 0; bus.vc_lookup_data = 32'hEEEE0012; bus.vc_repl_way = 1; #1;
    chk("b_lookup_en", bus.vc_lookup_en, 1'b1);
    chk("b_lookup_nofill", bus.fill_val, 1'b0);
    step(); bus.vc_lookup_hit = 0; bus.vc_lookup_data = 0; #1;
    chk("b_fill_val", bus.fill_val, 1'b1);
    chk("b_fill_from_vc", bus.fill_from_vc, 1'b1);
    chk("b_fill_dirty", bus.fill_dirty, 1'b0);
    chk("b_fill_data", bus.fill_data, 32'hEEEE0012);
    chk("b_wen", bus.vc_write_en, 1'b1);
    chk("b_way", bus.vc_write_way, 1'b0);
    chk("b_tag", bus.vc_write_tag, 8'h34);
    chk("b_idx", bus.vc_write_idx, 4'h2);
    chk("b_valid", bus.vc_write_valid, 1'b1);
    chk("b_data", bus.vc_write_data, 32'h34343434);
    chk("b_nomem", bus.memreq_val, 1'b0);
    step(); #1;
    chk("b_done_rdy", bus.miss_rdy, 1'b1);

    // Miss with 5-cycle memreq stall; dirty evict {56,3} lands in empty way1
    miss(8'h40, 4'h3, 1'b1, 1'b1, 8'h56, 32'h56565656); #1;
    step(); bus.miss_val = 0; bus.vc_repl_way = 1; #1;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("c_stall_val", bus.memreq_val, 1'b1);
      chk("c_stall_addr", bus.memreq_addr, 12'h403);
    end
    bus.memreq_rdy = 1;
    step(); bus.memreq_rdy = 0; bus.memresp_val = 1; bus.memresp_data = 32'h11112222; #1;
    chk("c_fill_val", bus.fill_val, 1'b1);
    chk("c_fill_data", bus.fill_data, 32'h11112222);
    step(); bus.memresp_val = 0; #1;
    chk("c_ins_wen", bus.vc_write_en, 1'b1);
    chk("c_ins_way", bus.vc_write_way, 1'b1);
    chk("c_ins_tag", bus.vc_write_tag, 8'h56);
    chk("c_ins_idx", bus.vc_write_idx, 4'h3);
    step(); #1;

    // Both ways valid and dirty, repl=1: read, fill, VC_RD, writeback, insert
    bus.vc_valid_bits = 2'b11;
    miss(8'h77, 4'h5, 1'b1, 1'b0, 8'h78, 32'h78787878); #1;
    step(); bus.miss_val = 0; bus.vc_repl_way = 1; #1;
    step(); bus.memreq_rdy = 1; #1;
    chk("d_rdreq_addr", bus.memreq_addr, 12'h775);
    step(); bus.memreq_rdy = 0; bus.memresp_val = 1; bus.memresp_data = 32'h99999999; #1;
    chk("d_fill_val", bus.fill_val, 1'b1);
    chk("d_fill_data", bus.fill_data, 32'h99999999);
    chk("d_fill_nowrite", bus.vc_write_en, 1'b0);
    step(); bus.memresp_val = 0; bus.vc_lookup_data = 32'h5A5A5A5A; #1;
    chk("d_vcrd_en", bus.vc_lookup_en, 1'b1);
    chk("d_vcrd_tag", bus.vc_lookup_tag, 8'h56);
    chk("d_vcrd_idx", bus.vc_lookup_idx, 4'h3);
    chk("d_vcrd_nowrite", bus.vc_write_en, 1'b0);
    step(); bus.vc_lookup_data = 0; #1;
    chk("d_wb_val", bus.memreq_val, 1'b1);
    chk("d_wb_type", bus.memreq_type, 1'b1);
    chk("d_wb_addr", bus.memreq_addr, 12'h563);
    chk("d_wb_data", bus.memreq_data, 32'h5A5A5A5A);
    step(); bus.memreq_rdy = 1; #1;
    chk("d_wb_held", bus.memreq_data, 32'h5A5A5A5A);
    step(); bus.memreq_rdy = 0; #1;
    chk("d_ins_wen", bus.vc_write_en, 1'b1);
    chk("d_ins_way", bus.vc_write_way, 1'b1);
    chk("d_ins_tag", bus.vc_write_tag, 8'h78);
    chk("d_ins_idx", bus.vc_write_idx, 4'h5);
    chk("d_ins_data", bus.vc_write_data, 32'h78787878);
    chk("d_ins_nomem", bus.memreq_val, 1'b0);
    step(); #1;
    chk("d_done_rdy", bus.miss_rdy, 1'b1);

    // Hit on way1 with no evict line: invalidate, clean fill
    miss(8'h78, 4'h5, 1'b0, 1'b0, 8'h00, 32'h0); #1;
    step(); bus.miss_val = 0;
    bus.vc_lookup_hit = 1; bus.vc_lookup_way = 1; bus.vc_lookup_data = 32'h78787878; #1;
    step(); bus.vc_lookup_hit = 0; #1;
    chk("e_fill_data", bus.fill_data, 32'h78787878);
    chk("e_fill_dirty", bus.fill_dirty, 1'b0);
    chk("e_way", bus.vc_write_way, 1'b1);
    chk("e_valid", bus.vc_write_valid, 1'b0);
    step(); #1;

`ifdef RISCV_VICTIM_CTRL_PERF_EN
    chk("perf_hit", perf_hit, 32'd2);
    chk("perf_miss", perf_miss, 32'd3);
    chk("perf_wb", perf_wb, 32'd1);
`else
    chk("perf_hit_tied", perf_hit, 32'd0);
    chk("perf_miss_tied", perf_miss, 32'd0);
    chk("perf_wb_tied", perf_wb, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
